// File: rtl/interval_histogram.sv
// -----------------------------------------------------------------------------
// interval_histogram
//
// Purpose:
//   Accumulates one-hot interval vectors from the interval classifier into one
//   saturating counter per interval. On a dump request, it streams every bin
//   out as a valid/ready beat sequence, bin 0 first and bin NUM-1 last. After
//   the final beat, it clears all counters so that a new capture window starts.
//   The resulting distributions are used for range calibration of the DAL
//   datapath.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   interval sample valid
//   in_ready_o   sample can be accepted (high only while accumulating)
//   interval_i   one-hot interval vector (bit k = sample lies in interval k)
//   clear_i      synchronous clear of all bins and the error counter
//   dump_i       single-cycle request to stream the histogram out
//   out_valid_o  dump beat valid
//   out_ready_i  downstream accepts the dump beat
//   out_bin_o    bin index of the current beat
//   out_count_o  count of that bin
//   out_last_o   current beat is bin NUM-1
//   err_cnt_o    number of accepted non-one-hot samples (saturating)
//   busy_o       high while the dump is in progress
// -----------------------------------------------------------------------------
module interval_histogram #(
   parameter  int NUM   = 8,
   parameter  int CNT_W = 16,
   localparam int IDX_W = $clog2(NUM)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [NUM-1:0]   interval_i,
   input  logic             clear_i,
   input  logic             dump_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [IDX_W-1:0] out_bin_o,
   output logic [CNT_W-1:0] out_count_o,
   output logic             out_last_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic             busy_o
);

   typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] bin_q [NUM];
   logic [CNT_W-1:0] bin_d [NUM];
   logic [CNT_W-1:0] err_q, err_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             accept;
   logic             is_onehot;
   logic             clear_now;
   logic             beat_fire;
   logic             dump_done;
   logic [NUM-1:0]   bin_hit;

   // Samples are only taken while accumulating; during a dump they are
   // back-pressured, not dropped.
   assign accept    = (state_q == ACCUM) && in_valid_i;
   // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
   assign is_onehot = (interval_i != '0) &&
                      ((interval_i & (interval_i - NUM'(1))) == '0);
   assign clear_now = (state_q == ACCUM) && clear_i;
   assign beat_fire = (state_q == DUMP) && out_ready_i;
   assign dump_done = beat_fire && (idx_q == LAST_IDX);

   genvar gi;
   generate
      for (gi = 0; gi < NUM; gi++) begin : g_hit
         assign bin_hit[gi] = accept && is_onehot && interval_i[gi];
      end
   endgenerate

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (dump_i) state_d = DUMP;
         DUMP:    if (dump_done) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   // The beat is driven straight from registered state. Bins are frozen for the
   // whole dump, so the count mux output is stable while a beat is stalled.
   always_comb begin
      in_ready_o  = (state_q == ACCUM);
      busy_o      = (state_q == DUMP);
      out_valid_o = (state_q == DUMP);
      out_bin_o   = idx_q;
      out_count_o = '0;
      out_last_o  = 1'b0;
      if (state_q == DUMP) begin
         out_count_o = bin_q[idx_q];
         out_last_o  = (idx_q == LAST_IDX);
      end
   end

   // ----------------------------------------------------------- datapath
   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         bin_d[i] = bin_q[i];
         // Clear takes effect before the increment so that a same-cycle
         // sample survives the clear.
         if (clear_now || dump_done) begin
            bin_d[i] = '0;
         end
         if (bin_hit[i] && (bin_d[i] != CNT_MAX)) begin
            bin_d[i] = bin_d[i] + CNT_W'(1);
         end
      end

      err_d = err_q;
      if (clear_now || dump_done) begin
         err_d = '0;
      end
      if (accept && !is_onehot && (err_d != CNT_MAX)) begin
         err_d = err_d + CNT_W'(1);
      end

      idx_d = idx_q;
      if (state_q == ACCUM) begin
         idx_d = '0;
      end else if (beat_fire) begin
         idx_d = dump_done ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM; i++) begin
            bin_q[i] <= '0;
         end
         err_q <= '0;
         idx_q <= '0;
      end else begin
         for (int i = 0; i < NUM; i++) begin
            bin_q[i] <= bin_d[i];
         end
         err_q <= err_d;
         idx_q <= idx_d;
      end
   end

   assign err_cnt_o = err_q;

endmodule

// File: tb/tb_interval_histogram.sv
module tb_interval_histogram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // Main instance (default widths)
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  interval = '0;
   logic        clear = 1'b0;
   logic        dump = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  out_bin;
   logic [15:0] out_count;
   logic        out_last;
   logic [15:0] err_cnt;
   logic        busy;

   // Narrow-counter instance for saturation
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [7:0]  s_interval = '0;
   logic        s_dump = 1'b0;
   logic        s_out_valid;
   logic [2:0]  s_out_bin;
   logic [3:0]  s_out_count;
   logic        s_out_last;
   logic [3:0]  s_err_cnt;
   logic        s_busy;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_bins [8];

   always #5 clk = ~clk;

   interval_histogram #(.NUM(8), .CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .interval_i(interval),
      .clear_i(clear), .dump_i(dump),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_bin_o(out_bin), .out_count_o(out_count), .out_last_o(out_last),
      .err_cnt_o(err_cnt), .busy_o(busy)
   );

   interval_histogram #(.NUM(8), .CNT_W(4)) dut_s (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .interval_i(s_interval),
      .clear_i(1'b0), .dump_i(s_dump),
      .out_valid_o(s_out_valid), .out_ready_i(1'b1),
      .out_bin_o(s_out_bin), .out_count_o(s_out_count), .out_last_o(s_out_last),
      .err_cnt_o(s_err_cnt), .busy_o(s_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v);
      in_valid = 1'b1;
      interval = v;
      step();
      in_valid = 1'b0;
      $display("sample %b accepted, err_cnt=%0d", v, err_cnt);
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 8; i++) exp_bins[i] = 0;
   endtask

   // Request a dump and check every beat against exp_bins. If stall_at is a
   // valid bin, out_ready is dropped for 3 cycles on that beat.
   task automatic dump_check(input string name, input int stall_at);
      dump = 1'b1;
      step();
      dump = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == stall_at) begin
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               step();
               check($sformatf("%s stall%0d valid", name, c), 32'(out_valid), 32'd1);
               check($sformatf("%s stall%0d bin", name, c), 32'(out_bin), 32'(k));
               check($sformatf("%s stall%0d count", name, c), 32'(out_count), 32'(exp_bins[k]));
               check($sformatf("%s stall%0d last", name, c), 32'(out_last), 32'(k == 7));
               check($sformatf("%s stall%0d in_ready", name, c), 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
         end
         check($sformatf("%s beat%0d valid", name, k), 32'(out_valid), 32'd1);
         check($sformatf("%s beat%0d bin", name, k), 32'(out_bin), 32'(k));
         check($sformatf("%s beat%0d count", name, k), 32'(out_count), 32'(exp_bins[k]));
         check($sformatf("%s beat%0d last", name, k), 32'(out_last), 32'(k == 7));
         check($sformatf("%s beat%0d in_ready", name, k), 32'(in_ready), 32'd0);
         check($sformatf("%s beat%0d busy", name, k), 32'(busy), 32'd1);
         $display("%s beat bin=%0d count=%0d last=%0d", name, out_bin, out_count, out_last);
         step();
      end
      check({name, " end valid"}, 32'(out_valid), 32'd0);
      check({name, " end busy"}, 32'(busy), 32'd0);
      check({name, " end err"}, 32'(err_cnt), 32'd0);
   endtask

   initial begin
      // ---------------- reset state
      #2;
      check("rst valid", 32'(out_valid), 32'd0);
      check("rst bin", 32'(out_bin), 32'd0);
      check("rst count", 32'(out_count), 32'd0);
      check("rst last", 32'(out_last), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst err", 32'(err_cnt), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();

      // ---------------- basic accumulate + dump
      send(8'b0000_0100);
      send(8'b0000_0100);
      send(8'b0000_0100);
      send(8'b0010_0000);
      clear_exp();
      exp_bins[2] = 3;
      exp_bins[5] = 1;
      dump_check("basic", -1);
      check("basic after in_ready", 32'(in_ready), 32'd1);

      // ---------------- non-one-hot samples
      send(8'b0000_0000);
      send(8'b0001_0001);
      check("err count", 32'(err_cnt), 32'd2);
      clear_exp();
      dump_check("err", -1);

      // ---------------- stall at bin 4, sample held during dump
      send(8'b0001_0000);
      send(8'b0001_0000);
      send(8'b0000_1000);
      clear_exp();
      exp_bins[4] = 2;
      exp_bins[3] = 1;
      in_valid = 1'b1;
      interval = 8'b0000_0010;
      check("held in_ready pre", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      dump = 1'b1;
      step();
      dump = 1'b0;
      // Sample presented while dumping must wait for ACCUM.
      in_valid = 1'b1;
      // Rewind: dump_check issues its own request; re-run from a fresh dump
      // is not possible, so the stall dump is checked inline via a helper loop.
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               step();
               check($sformatf("stall%0d bin", c), 32'(out_bin), 32'd4);
               check($sformatf("stall%0d count", c), 32'(out_count), 32'd2);
               check($sformatf("stall%0d last", c), 32'(out_last), 32'd0);
               check($sformatf("stall%0d valid", c), 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
         end
         check($sformatf("stall beat%0d bin", k), 32'(out_bin), 32'(k));
         check($sformatf("stall beat%0d count", k), 32'(out_count), 32'(exp_bins[k]));
         check($sformatf("stall beat%0d last", k), 32'(out_last), 32'(k == 7));
         check($sformatf("stall beat%0d in_ready", k), 32'(in_ready), 32'd0);
         $display("stall beat bin=%0d count=%0d last=%0d", out_bin, out_count, out_last);
         step();
      end
      check("stall end valid", 32'(out_valid), 32'd0);
      check("held in_ready post", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      $display("held sample %b accepted after dump", interval);
      clear_exp();
      exp_bins[1] = 1;
      dump_check("held", -1);

      // ---------------- clear with simultaneous sample, dump with sample
      send(8'b0000_1000);
      send(8'b1100_0000);
      check("pre-clear err", 32'(err_cnt), 32'd1);
      in_valid = 1'b1;
      interval = 8'b0000_0010;
      clear = 1'b1;
      step();
      clear = 1'b0;
      in_valid = 1'b0;
      check("post-clear err", 32'(err_cnt), 32'd0);
      send(8'b0100_0000);
      in_valid = 1'b1;
      interval = 8'b0100_0000;
      clear_exp();
      exp_bins[1] = 1;
      exp_bins[6] = 2;
      // dump_check raises dump_i on the same edge as this sample.
      fork
         begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
         end
      join_none
      dump_check("clr+dump", 2);

      // ---------------- reset mid-dump
      send(8'b0000_0100);
      dump = 1'b1;
      step();
      dump = 1'b0;
      for (int k = 0; k < 3; k++) step();
      check("mid beat bin", 32'(out_bin), 32'd3);
      check("mid beat valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid rst valid", 32'(out_valid), 32'd0);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst bin", 32'(out_bin), 32'd0);
      check("mid rst count", 32'(out_count), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("post rst in_ready", 32'(in_ready), 32'd1);
      check("post rst valid", 32'(out_valid), 32'd0);
      clear_exp();
      dump_check("post-rst", -1);

      // ---------------- saturation (4-bit counters)
      s_in_valid = 1'b1;
      s_interval = 8'b0000_0001;
      for (int i = 0; i < 20; i++) step();
      s_in_valid = 1'b0;
      s_dump = 1'b1;
      step();
      s_dump = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("sat beat%0d valid", k), 32'(s_out_valid), 32'd1);
         check($sformatf("sat beat%0d bin", k), 32'(s_out_bin), 32'(k));
         check($sformatf("sat beat%0d count", k), 32'(s_out_count), (k == 0) ? 32'd15 : 32'd0);
         check($sformatf("sat beat%0d last", k), 32'(s_out_last), 32'(k == 7));
         $display("sat beat bin=%0d count=%0d", s_out_bin, s_out_count);
         step();
      end
      check("sat end valid", 32'(s_out_valid), 32'd0);
      check("sat err", 32'(s_err_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog: an unexpected hang still ends with a report.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
